// File: rtl/clk_reset_sequencer.sv
// Multi-channel clock divider with staggered power-up core-reset release and per-channel re-reset.
// Optional CLK_GATE_EN adds a per-channel gate_en input that freezes the divider of that channel.
module clk_reset_sequencer #(
    parameter int NUM_CH         = 2,
    parameter int DIV_WIDTH      = 8,
    parameter int DEFAULT_DIV    = 1,
    parameter int RESET_CYCLES   = 20,
    parameter int STAGGER_CYCLES = 4,
    parameter int CNT_WIDTH      = 16,
    parameter int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
`ifdef CLK_GATE_EN
    input  logic [NUM_CH-1:0]    gate_en,
`endif
    input  logic                 div_wr,
    input  logic [CH_W-1:0]      div_ch,
    input  logic [DIV_WIDTH-1:0] div_value,
    input  logic [NUM_CH-1:0]    rst_req,
    output logic [NUM_CH-1:0]    clk_out,
    output logic [NUM_CH-1:0]    clk_en_out,
    output logic [NUM_CH-1:0]    reset_out,
    output logic [NUM_CH-1:0]    rst_busy,
    output logic                 ready
);

    localparam logic [DIV_WIDTH-1:0] DEF_DIV  = (DEFAULT_DIV == 0) ? DIV_WIDTH'(1) : DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0] HOLD_END = CNT_WIDTH'(RESET_CYCLES);
    localparam logic [CNT_WIDTH-1:0] LAST_REL = CNT_WIDTH'(RESET_CYCLES + (NUM_CH - 1) * STAGGER_CYCLES);

    typedef enum logic [1:0] {HOLD, STAGGER, RUN} seq_state_t;

    seq_state_t           state, state_next;
    logic [CNT_WIDTH-1:0] seq_cnt, seq_cnt_next;
    logic [CNT_WIDTH-1:0] rr_cnt      [NUM_CH];
    logic [CNT_WIDTH-1:0] rr_cnt_next [NUM_CH];
    logic [NUM_CH-1:0]    busy_next;

    logic [DIV_WIDTH-1:0] div_cnt  [NUM_CH];
    logic [DIV_WIDTH-1:0] div_cur  [NUM_CH];
    logic [DIV_WIDTH-1:0] div_pend [NUM_CH];
    logic [NUM_CH-1:0]    pend_valid;
    logic [NUM_CH-1:0]    run_en;

`ifdef CLK_GATE_EN
    assign run_en = gate_en;
`else
    assign run_en = '1;
`endif

    function automatic logic [CNT_WIDTH-1:0] release_at(input int ch);
        return CNT_WIDTH'(RESET_CYCLES + ch * STAGGER_CYCLES);
    endfunction

    // New divisors wait in div_pend until the next wrap so a half-period is never cut short
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_cnt[i]  <= '0;
                div_cur[i]  <= DEF_DIV;
                div_pend[i] <= DEF_DIV;
            end
            pend_valid <= '0;
            clk_out    <= '0;
            clk_en_out <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                clk_en_out[i] <= 1'b0;
                if (run_en[i]) begin
                    if (div_cnt[i] >= div_cur[i] - DIV_WIDTH'(1)) begin
                        div_cnt[i]    <= '0;
                        clk_out[i]    <= ~clk_out[i];
                        clk_en_out[i] <= ~clk_out[i];
                        if (pend_valid[i]) begin
                            div_cur[i]    <= div_pend[i];
                            pend_valid[i] <= 1'b0;
                        end
                    end else begin
                        div_cnt[i] <= div_cnt[i] + DIV_WIDTH'(1);
                    end
                end
                if (div_wr && (div_ch == CH_W'(i))) begin
                    div_pend[i]   <= (div_value == '0) ? DIV_WIDTH'(1) : div_value;
                    pend_valid[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next   = state;
        seq_cnt_next = seq_cnt;
        busy_next    = rst_busy;
        for (int i = 0; i < NUM_CH; i++) begin
            rr_cnt_next[i] = rr_cnt[i];
        end
        case (state)
            HOLD, STAGGER: begin
                seq_cnt_next = seq_cnt + CNT_WIDTH'(1);
                for (int i = 0; i < NUM_CH; i++) begin
                    busy_next[i] = (seq_cnt_next < release_at(i));
                end
                if (seq_cnt_next >= LAST_REL) begin
                    state_next = RUN;
                end else if (seq_cnt_next >= HOLD_END) begin
                    state_next = STAGGER;
                end
            end
            RUN: begin
                // A request while busy simply reloads the count, stretching the reset
                for (int i = 0; i < NUM_CH; i++) begin
                    if (rst_req[i]) begin
                        busy_next[i]   = 1'b1;
                        rr_cnt_next[i] = HOLD_END;
                    end else if (rst_busy[i]) begin
                        if (rr_cnt[i] <= CNT_WIDTH'(1)) begin
                            busy_next[i] = 1'b0;
                        end
                        rr_cnt_next[i] = rr_cnt[i] - CNT_WIDTH'(1);
                    end
                end
            end
            default: state_next = HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= HOLD;
            seq_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                rr_cnt[i] <= '0;
            end
            rst_busy  <= '1;
            reset_out <= '1;
            ready     <= 1'b0;
        end else begin
            state   <= state_next;
            seq_cnt <= seq_cnt_next;
            for (int i = 0; i < NUM_CH; i++) begin
                rr_cnt[i] <= rr_cnt_next[i];
            end
            rst_busy  <= busy_next;
            reset_out <= busy_next;
            ready     <= (state_next == RUN) && (busy_next == '0);
        end
    end

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Scoreboard bench for clk_reset_sequencer: stimulus queues expected outputs tagged with a cycle number,
// a monitor pops and compares them just after each clock edge.
module tb_clk_reset_sequencer;

    localparam int NUM_CH = 2;

    localparam int SIG_CLK   = 0;
    localparam int SIG_EN    = 1;
    localparam int SIG_RST   = 2;
    localparam int SIG_BUSY  = 3;
    localparam int SIG_READY = 4;

    typedef struct {
        int         when;
        int         sig;
        logic [1:0] exp;
        string      name;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              div_wr = 1'b0;
    logic [0:0]        div_ch = '0;
    logic [7:0]        div_value = '0;
    logic [NUM_CH-1:0] rst_req = '0;
    logic [NUM_CH-1:0] clk_out, clk_en_out, reset_out, rst_busy;
    logic              ready;
`ifdef CLK_GATE_EN
    logic [NUM_CH-1:0] gate_en = '1;
`endif

    exp_t sb[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    int   base;

    clk_reset_sequencer #(
        .NUM_CH(2), .DIV_WIDTH(8), .DEFAULT_DIV(1),
        .RESET_CYCLES(20), .STAGGER_CYCLES(4), .CNT_WIDTH(16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
`ifdef CLK_GATE_EN
        .gate_en    (gate_en),
`endif
        .div_wr     (div_wr),
        .div_ch     (div_ch),
        .div_value  (div_value),
        .rst_req    (rst_req),
        .clk_out    (clk_out),
        .clk_en_out (clk_en_out),
        .reset_out  (reset_out),
        .rst_busy   (rst_busy),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] sample(input int sig);
        case (sig)
            SIG_CLK:  return clk_out;
            SIG_EN:   return clk_en_out;
            SIG_RST:  return reset_out;
            SIG_BUSY: return rst_busy;
            default:  return {1'b0, ready};
        endcase
    endfunction

    task automatic checkOutput(input exp_t e);
        logic [1:0] act;
        act = sample(e.sig);
        compared++;
        if (e.when != cyc || act !== e.exp) begin
            mismatched++;
            $display("[TB] FAIL %s @cycle %0d (seen at %0d): got %b expected %b", e.name, e.when, cyc, act, e.exp);
        end
    endtask

    // Monitor: everything due at or before this edge is popped and compared
    always @(posedge clk) begin
        #1;
        while (sb.size() > 0 && sb[0].when <= cyc) begin
            checkOutput(sb.pop_front());
        end
    end

    task automatic pushExpect(input int when, input int sig, input logic [1:0] exp, input string name);
        exp_t e;
        e.when = when;
        e.sig  = sig;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic pushResetValues(input int when, input string name);
        pushExpect(when, SIG_CLK,   2'b00, {name, "_clk"});
        pushExpect(when, SIG_EN,    2'b00, {name, "_en"});
        pushExpect(when, SIG_RST,   2'b11, {name, "_rst"});
        pushExpect(when, SIG_BUSY,  2'b11, {name, "_busy"});
        pushExpect(when, SIG_READY, 2'b00, {name, "_ready"});
    endtask

    task automatic pushReleaseSequence(input int r, input string name);
        pushExpect(r + 1,  SIG_CLK,   2'b11, {name, "_clk_c1"});
        pushExpect(r + 1,  SIG_EN,    2'b11, {name, "_en_c1"});
        pushExpect(r + 2,  SIG_CLK,   2'b00, {name, "_clk_c2"});
        pushExpect(r + 2,  SIG_EN,    2'b00, {name, "_en_c2"});
        pushExpect(r + 19, SIG_RST,   2'b11, {name, "_rst_c19"});
        pushExpect(r + 20, SIG_RST,   2'b10, {name, "_rst_c20"});
        pushExpect(r + 20, SIG_BUSY,  2'b10, {name, "_busy_c20"});
        pushExpect(r + 23, SIG_RST,   2'b10, {name, "_rst_c23"});
        pushExpect(r + 23, SIG_READY, 2'b00, {name, "_ready_c23"});
        pushExpect(r + 24, SIG_RST,   2'b00, {name, "_rst_c24"});
        pushExpect(r + 24, SIG_BUSY,  2'b00, {name, "_busy_c24"});
        pushExpect(r + 24, SIG_READY, 2'b01, {name, "_ready_c24"});
    endtask

    // Drive one input set, then let n clock cycles pass (returns just after a negedge)
    task automatic applyStimulus(input logic rn, input logic [1:0] req, input logic wr,
                                 input logic [7:0] val, input int n);
        reset_n   = rn;
        rst_req   = req;
        div_wr    = wr;
        div_ch    = 1'b1;
        div_value = val;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(negedge clk);

        // Power-up: reset values, then release with rst_req ignored while sequencing
        base = cyc;
        pushResetValues(base + 1, "por");
        applyStimulus(1'b0, 2'b00, 1'b0, 8'd0, 1);
        base = cyc;
        pushReleaseSequence(base, "seq");
        pushExpect(base + 25, SIG_RST,   2'b00, "seq_req_ignored_rst");
        pushExpect(base + 25, SIG_READY, 2'b01, "seq_req_ignored_ready");
        applyStimulus(1'b1, 2'b00, 1'b0, 8'd0, 10);
        applyStimulus(1'b1, 2'b10, 1'b0, 8'd0, 12);
        applyStimulus(1'b1, 2'b00, 1'b0, 8'd0, 4);

        // Divisor change on ch1 to 3, later 6 then 0 before the wrap (0 wins, period 2)
        base = cyc;
        pushExpect(base + 1,  SIG_CLK, 2'b11, "div_c1_clk");
        pushExpect(base + 2,  SIG_CLK, 2'b00, "div_c2_clk");
        pushExpect(base + 3,  SIG_CLK, 2'b01, "div_c3_clk");
        pushExpect(base + 3,  SIG_EN,  2'b01, "div_c3_en");
        pushExpect(base + 4,  SIG_CLK, 2'b00, "div_c4_clk");
        pushExpect(base + 5,  SIG_CLK, 2'b11, "div_c5_clk");
        pushExpect(base + 5,  SIG_EN,  2'b11, "div_c5_en");
        pushExpect(base + 6,  SIG_CLK, 2'b10, "div_c6_clk");
        pushExpect(base + 6,  SIG_EN,  2'b00, "div_c6_en");
        pushExpect(base + 7,  SIG_CLK, 2'b11, "div_c7_clk");
        pushExpect(base + 7,  SIG_EN,  2'b01, "div_c7_en");
        pushExpect(base + 8,  SIG_CLK, 2'b00, "div_c8_clk");
        pushExpect(base + 11, SIG_CLK, 2'b11, "div_last_wr_c11_clk");
        pushExpect(base + 11, SIG_EN,  2'b11, "div_last_wr_c11_en");
        pushExpect(base + 12, SIG_CLK, 2'b00, "div_last_wr_c12_clk");
        pushExpect(base + 13, SIG_CLK, 2'b11, "div_last_wr_c13_clk");
        applyStimulus(1'b1, 2'b00, 1'b1, 8'd3, 1);
        applyStimulus(1'b1, 2'b00, 1'b0, 8'd0, 7);
        applyStimulus(1'b1, 2'b00, 1'b1, 8'd6, 1);
        applyStimulus(1'b1, 2'b00, 1'b1, 8'd0, 1);
        applyStimulus(1'b1, 2'b00, 1'b0, 8'd0, 4);

        // Re-reset: ch0 at t=0 extended at t=10, ch1 independently at t=4
        base = cyc;
        pushExpect(base + 1,  SIG_RST,   2'b01, "rr_c1_rst");
        pushExpect(base + 1,  SIG_BUSY,  2'b01, "rr_c1_busy");
        pushExpect(base + 1,  SIG_READY, 2'b00, "rr_c1_ready");
        pushExpect(base + 5,  SIG_RST,   2'b11, "rr_c5_rst");
        pushExpect(base + 20, SIG_RST,   2'b11, "rr_c20_rst");
        pushExpect(base + 21, SIG_RST,   2'b11, "rr_extend_c21_rst");
        pushExpect(base + 24, SIG_BUSY,  2'b11, "rr_c24_busy");
        pushExpect(base + 25, SIG_RST,   2'b01, "rr_ch1_done_c25_rst");
        pushExpect(base + 25, SIG_READY, 2'b00, "rr_c25_ready");
        pushExpect(base + 30, SIG_RST,   2'b01, "rr_c30_rst");
        pushExpect(base + 31, SIG_RST,   2'b00, "rr_done_c31_rst");
        pushExpect(base + 31, SIG_BUSY,  2'b00, "rr_done_c31_busy");
        pushExpect(base + 31, SIG_READY, 2'b01, "rr_done_c31_ready");
        applyStimulus(1'b1, 2'b01, 1'b0, 8'd0, 1);
        applyStimulus(1'b1, 2'b00, 1'b0, 8'd0, 3);
        applyStimulus(1'b1, 2'b10, 1'b0, 8'd0, 1);
        applyStimulus(1'b1, 2'b00, 1'b0, 8'd0, 5);
        applyStimulus(1'b1, 2'b01, 1'b0, 8'd0, 1);
        applyStimulus(1'b1, 2'b00, 1'b0, 8'd0, 21);

        // reset_n pulse in RUN, then again during STAGGER: the sequence replays
        base = cyc;
        pushResetValues(base + 1, "mid_run_rst");
        applyStimulus(1'b0, 2'b00, 1'b0, 8'd0, 1);
        base = cyc;
        pushExpect(base + 21, SIG_RST, 2'b10, "stagger_before_rst");
        applyStimulus(1'b1, 2'b00, 1'b0, 8'd0, 21);
        base = cyc;
        pushResetValues(base + 1, "stagger_rst");
        applyStimulus(1'b0, 2'b00, 1'b0, 8'd0, 1);
        base = cyc;
        pushReleaseSequence(base, "replay");
        applyStimulus(1'b1, 2'b00, 1'b0, 8'd0, 26);

`ifdef CLK_GATE_EN
        // ch1 at div 2 frozen for 5 cycles mid high phase, then finishes that half-period
        base = cyc;
        pushExpect(base + 4,  SIG_CLK, 2'b10, "gate_c4_clk");
        pushExpect(base + 4,  SIG_EN,  2'b10, "gate_c4_en");
        pushExpect(base + 7,  SIG_CLK, 2'b11, "gate_frozen_c7_clk");
        pushExpect(base + 7,  SIG_EN,  2'b01, "gate_frozen_c7_en");
        pushExpect(base + 8,  SIG_EN,  2'b00, "gate_frozen_c8_en");
        pushExpect(base + 10, SIG_CLK, 2'b10, "gate_frozen_c10_clk");
        pushExpect(base + 11, SIG_CLK, 2'b01, "gate_resume_c11_clk");
        pushExpect(base + 13, SIG_CLK, 2'b11, "gate_resume_c13_clk");
        pushExpect(base + 13, SIG_EN,  2'b11, "gate_resume_c13_en");
        applyStimulus(1'b1, 2'b00, 1'b1, 8'd2, 1);
        applyStimulus(1'b1, 2'b00, 1'b0, 8'd0, 4);
        gate_en = 2'b01;
        applyStimulus(1'b1, 2'b00, 1'b0, 8'd0, 5);
        gate_en = 2'b11;
        applyStimulus(1'b1, 2'b00, 1'b0, 8'd0, 4);
`endif

        applyStimulus(1'b1, 2'b00, 1'b0, 8'd0, 2);
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
